toast_mem_stage: RTL and testbench
==================================

# toast_mem_stage

Pipeline MEM stage of the Toast RV32I core, directly downstream of the EX stage. It consumes the EX pipeline register outputs and performs load/store accesses on a single-outstanding data-memory request/acknowledge bus, including byte-lane steering, sign/zero extension and misalignment detection. It forwards results into the MEM/WB pipeline register and stalls the upstream stages while an access is pending.

## Interface
- TIMEOUT_CYCLES, 255: maximum wait cycles for `dmem_ack_i` before a bus-error exception; legal range 1..65535.
- clk_i  input  1  core clock.
- resetn_i  input  1  reset; asynchronous, active-low.
- EX_mem_wr_en_i, EX_mem_rd_en_i  input  1 each  store and load request from EX.
- EX_mem_op_i  input  4  access type (encoding under Operation).
- EX_rs2_data_i  input  32  store data; EX_rs2_addr_i  input  5  its source register.
- EX_alu_result_i  input  32  effective address, or the ALU result for non-memory instructions.
- EX_memtoreg_i, EX_rd_wr_en_i  input  1 each; EX_rd_addr_i  input  5.
- EX_exception_i  input  1  exception already raised upstream.
- WB_rd_wr_en_i  input  1; WB_rd_addr_i  input  5; WB_rd_wr_data_i  input  32  writeback bypass for store data.
- dmem_req_o  output  1; dmem_we_o  output  1; dmem_addr_o  output  32 (word-aligned, [1:0]=0); dmem_be_o  output  4; dmem_wdata_o  output  32.
- dmem_ack_i  input  1; dmem_rdata_i  input  32  read data, valid in the ack cycle.
- MEM_stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
- MEM_rd_wr_en_o, MEM_memtoreg_o  output  1 each; MEM_rd_addr_o  output  5; MEM_alu_result_o  output  32; MEM_load_data_o  output  32; MEM_exception_o  output  1.

## Operation
- mem_op encoding (shared constants): LB=0000, LH=0001, LW=0010, LBU=0100, LHU=0101, SB=1000, SH=1001, SW=1010. Any other code with rd_en or wr_en set raises an exception.
- Access is active when (rd_en|wr_en) & !EX_exception_i & aligned. Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Misaligned access, or an illegal op with rd_en/wr_en set: no bus request; the MEM register captures MEM_exception_o=1 and MEM_rd_wr_en_o=0.
- Store data: if WB_rd_wr_en_i & WB_rd_addr_i!=0 & WB_rd_addr_i==EX_rs2_addr_i, use WB_rd_wr_data_i; otherwise use EX_rs2_data_i.
- Store steering: SB replicates the byte to all lanes with be=0001<<addr[1:0]. SH replicates the halfword with be=0011<<addr[1:0]. SW uses be=1111.
- Load steering: select the byte/half by addr[1:0] from dmem_rdata_i. Sign-extend for LB/LH, zero-extend for LBU/LHU. be as for stores.
- FSM has two states, IDLE and WAIT.
  - IDLE: active access asserts dmem_req_o combinationally. If ack arrives the same cycle, the access completes. Otherwise go to WAIT and clear the timer.
  - WAIT: dmem_req_o and all request fields stay asserted and stable; the timer increments each cycle. On ack, complete and return to IDLE. When timer==TIMEOUT_CYCLES-1 without ack, drop the request, capture MEM_exception_o=1 with rd_wr_en=0, and return to IDLE.
- MEM_stall_o = dmem_req_o & !dmem_ack_i.
- While stalled, the MEM register captures a bubble: rd_wr_en=0, memtoreg=0, exception=0.
- Non-memory instructions pass through in one cycle: alu_result, rd, rd_wr_en, memtoreg and exception are registered; load_data is 0.
- EX_exception_i propagates to MEM_exception_o and suppresses the access.

## Timing
- Reset (async assert, sync release): FSM=IDLE, timer=0, all MEM_* outputs 0. dmem_req_o=0 while resetn_i is low.
- Latency: a non-memory instruction or a zero-wait access appears at MEM_* outputs one clock after it is presented. An N-wait access appears N+1 clocks after it is presented.
- dmem_ack_i outside an outstanding request is ignored.
- Reset asserted mid-WAIT abandons the request immediately. No completion follows.
- Back-to-back accesses are allowed. A new request may issue in the cycle after the ack.

## Structure
- mem_op codes and FSM state encodings go in toast_definitions.vh.
- Sub-module toast_mem_align: purely combinational; takes op, addr[1:0], store data and rdata; produces be, wdata, load data and a misaligned flag. Reused by any future cache.
- FSM, timer, and the MEM/WB register live in toast_mem_stage.

## Test plan
- SW 0xDEADBEEF to 0x100, ack on the same cycle: dmem_addr_o=0x100, be=1111, no stall; MEM outputs are registered one cycle later.
- LB at 0x103 with rdata 0x80xxxxxx and ack delayed 3 cycles: MEM_stall_o high for 3 cycles, then MEM_load_data_o=0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH at 0x102 with data 0x1234: be=1100, wdata=0x12341234. LW at 0x102: no request, MEM_exception_o=1, rd_wr_en=0.
- Store with rs2 matching WB_rd_addr (non-zero): wdata comes from WB_rd_wr_data_i. With rd=x0 matching, EX_rs2_data_i is used.
- TIMEOUT_CYCLES=4 with no ack: stall lasts exactly 4 cycles, then the request drops and MEM_exception_o=1.
- Assert resetn_i low during WAIT: dmem_req_o and MEM_* outputs go to 0 immediately. A late ack is ignored.

Source files
------------

// File: rtl/toast_mem_stage_pkg.sv
// toast_mem_stage_pkg: shared mem_op codes, MEM FSM states and op legality helper
package toast_mem_stage_pkg;
   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0010;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1010;
   typedef enum logic {IDLE, WAIT} state_t;
   function automatic logic op_legal(input logic [3:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
   endfunction
endpackage

// File: rtl/toast_mem_align.sv
// toast_mem_align: byte-lane steering, load extension and misalignment detection
module toast_mem_align
   import toast_mem_stage_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misaligned
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sx;
   assign byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
   assign half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   assign sx         = !op[2];
   assign misaligned = (op[1:0] == 2'b01 && addr_lo[0]) || (op[1:0] == 2'b10 && addr_lo != 2'b00);
   assign be         = op[1:0] == 2'b00 ? 4'b0001 << addr_lo :
                       op[1:0] == 2'b01 ? 4'b0011 << addr_lo : 4'b1111;
   assign wdata      = op[1:0] == 2'b00 ? {4{st_data[7:0]}} :
                       op[1:0] == 2'b01 ? {2{st_data[15:0]}} : st_data;
   assign ld_data    = op[1:0] == 2'b00 ? {{24{sx & byte_sel[7]}}, byte_sel} :
                       op[1:0] == 2'b01 ? {{16{sx & half_sel[15]}}, half_sel} : rdata;
endmodule

// File: rtl/toast_mem_stage.sv
// toast_mem_stage: RV32I MEM stage with single-outstanding dmem bus, timeout and MEM/WB register
module toast_mem_stage
   import toast_mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        EX_mem_wr_en_i,
   input  logic        EX_mem_rd_en_i,
   input  logic [3:0]  EX_mem_op_i,
   input  logic [31:0] EX_rs2_data_i,
   input  logic [4:0]  EX_rs2_addr_i,
   input  logic [31:0] EX_alu_result_i,
   input  logic        EX_memtoreg_i,
   input  logic        EX_rd_wr_en_i,
   input  logic [4:0]  EX_rd_addr_i,
   input  logic        EX_exception_i,
   input  logic        WB_rd_wr_en_i,
   input  logic [4:0]  WB_rd_addr_i,
   input  logic [31:0] WB_rd_wr_data_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        MEM_stall_o,
   output logic        MEM_rd_wr_en_o,
   output logic        MEM_memtoreg_o,
   output logic [4:0]  MEM_rd_addr_o,
   output logic [31:0] MEM_alu_result_o,
   output logic [31:0] MEM_load_data_o,
   output logic        MEM_exception_o
);
   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [31:0] st_q, st_fwd, st_data, ld_data;
   logic        rw, misaligned, access, err, done, timeout, fwd;
   assign rw      = EX_mem_wr_en_i | EX_mem_rd_en_i;
   assign access  = rw & !EX_exception_i & op_legal(EX_mem_op_i) & !misaligned;
   assign err     = rw & !EX_exception_i & (!op_legal(EX_mem_op_i) | misaligned);
   assign fwd     = WB_rd_wr_en_i && WB_rd_addr_i != 5'd0 && WB_rd_addr_i == EX_rs2_addr_i;
   assign st_fwd  = fwd ? WB_rd_wr_data_i : EX_rs2_data_i;
   // WB moves on while we wait, so the store data seen at issue is held
   assign st_data = state_q == WAIT ? st_q : st_fwd;
   toast_mem_align u_align (
      .op         (EX_mem_op_i),
      .addr_lo    (EX_alu_result_i[1:0]),
      .st_data    (st_data),
      .rdata      (dmem_rdata_i),
      .be         (dmem_be_o),
      .wdata      (dmem_wdata_o),
      .ld_data    (ld_data),
      .misaligned (misaligned)
   );
   assign dmem_we_o   = EX_mem_wr_en_i;
   assign dmem_addr_o = {EX_alu_result_i[31:2], 2'b00};
   assign done        = dmem_req_o & dmem_ack_i;
   assign MEM_stall_o = dmem_req_o & !dmem_ack_i;
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      timeout    = 1'b0;
      dmem_req_o = 1'b0;
      if (state_q == IDLE) begin
         dmem_req_o = resetn_i & access;
         if (dmem_req_o && !dmem_ack_i) begin
            state_d = WAIT;
            timer_d = '0;
         end
      end else begin
         timeout    = timer_q == 16'(TIMEOUT_CYCLES - 1);
         dmem_req_o = resetn_i & !timeout;
         timer_d    = timer_q + 16'd1;
         if (timeout || dmem_ack_i) state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q          <= IDLE;
         timer_q          <= '0;
         st_q             <= '0;
         MEM_rd_wr_en_o   <= 1'b0;
         MEM_memtoreg_o   <= 1'b0;
         MEM_rd_addr_o    <= '0;
         MEM_alu_result_o <= '0;
         MEM_load_data_o  <= '0;
         MEM_exception_o  <= 1'b0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         if (state_q == IDLE) st_q <= st_fwd;
         MEM_rd_wr_en_o   <= !MEM_stall_o & !(err | timeout) & EX_rd_wr_en_i & !EX_exception_i;
         MEM_memtoreg_o   <= !MEM_stall_o & !(err | timeout) & EX_memtoreg_i;
         MEM_exception_o  <= !MEM_stall_o & (err | timeout | EX_exception_i);
         MEM_rd_addr_o    <= MEM_stall_o ? '0 : EX_rd_addr_i;
         MEM_alu_result_o <= MEM_stall_o ? '0 : EX_alu_result_i;
         MEM_load_data_o  <= (done & EX_mem_rd_en_i) ? ld_data : '0;
      end
   end
endmodule

// File: tb/tb_toast_mem_stage.sv
// tb_toast_mem_stage: directed vector table plus wait, timeout and reset sequences
module tb_toast_mem_stage;
   import toast_mem_stage_pkg::*;
   logic        clk_i = 1'b0, resetn_i = 1'b0;
   logic        EX_mem_wr_en_i, EX_mem_rd_en_i, EX_memtoreg_i, EX_rd_wr_en_i, EX_exception_i;
   logic [3:0]  EX_mem_op_i;
   logic [31:0] EX_rs2_data_i, EX_alu_result_i, WB_rd_wr_data_i, dmem_rdata_i;
   logic [4:0]  EX_rs2_addr_i, EX_rd_addr_i, WB_rd_addr_i;
   logic        WB_rd_wr_en_i, dmem_ack_i;
   logic        dmem_req_o, dmem_we_o, MEM_stall_o, MEM_rd_wr_en_o, MEM_memtoreg_o, MEM_exception_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o, MEM_alu_result_o, MEM_load_data_o;
   logic [3:0]  dmem_be_o;
   logic [4:0]  MEM_rd_addr_o;
   int checks = 0, failures = 0;
   toast_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .resetn_i(resetn_i),
      .EX_mem_wr_en_i(EX_mem_wr_en_i), .EX_mem_rd_en_i(EX_mem_rd_en_i), .EX_mem_op_i(EX_mem_op_i),
      .EX_rs2_data_i(EX_rs2_data_i), .EX_rs2_addr_i(EX_rs2_addr_i), .EX_alu_result_i(EX_alu_result_i),
      .EX_memtoreg_i(EX_memtoreg_i), .EX_rd_wr_en_i(EX_rd_wr_en_i), .EX_rd_addr_i(EX_rd_addr_i),
      .EX_exception_i(EX_exception_i), .WB_rd_wr_en_i(WB_rd_wr_en_i), .WB_rd_addr_i(WB_rd_addr_i),
      .WB_rd_wr_data_i(WB_rd_wr_data_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .MEM_stall_o(MEM_stall_o),
      .MEM_rd_wr_en_o(MEM_rd_wr_en_o), .MEM_memtoreg_o(MEM_memtoreg_o), .MEM_rd_addr_o(MEM_rd_addr_o),
      .MEM_alu_result_o(MEM_alu_result_o), .MEM_load_data_o(MEM_load_data_o),
      .MEM_exception_o(MEM_exception_o)
   );
   always #5 clk_i = ~clk_i;
   typedef struct {
      logic        wr, rd, m2r, rwe, exc, wbe, ack;
      logic [3:0]  op;
      logic [4:0]  rs2a, rda, wba;
      logic [31:0] rs2, alu, wbd, rdata;
      logic        e_req, e_rwe, e_m2r, e_exc;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wdata, e_load;
   } vec_t;
   vec_t vecs[$];
   function automatic vec_t blank();
      vec_t v;
      {v.wr, v.rd, v.m2r, v.rwe, v.exc, v.wbe, v.ack} = '0;
      {v.op, v.rs2a, v.rda, v.wba, v.rs2, v.alu, v.wbd, v.rdata} = '0;
      {v.e_req, v.e_rwe, v.e_m2r, v.e_exc, v.e_be, v.e_addr, v.e_wdata, v.e_load} = '0;
      return v;
   endfunction
   function automatic vec_t ldv(logic [3:0] op, logic [31:0] a, logic [31:0] rdata, logic [3:0] be, logic [31:0] ld);
      vec_t v = blank();
      v.rd = 1; v.op = op; v.alu = a; v.rdata = rdata; v.ack = 1; v.rwe = 1; v.m2r = 1; v.rda = 7;
      v.e_req = 1; v.e_be = be; v.e_addr = {a[31:2], 2'b00}; v.e_rwe = 1; v.e_m2r = 1; v.e_load = ld;
      return v;
   endfunction
   function automatic vec_t stv(logic [3:0] op, logic [31:0] a, logic [31:0] d, logic [3:0] be, logic [31:0] wd);
      vec_t v = blank();
      v.wr = 1; v.op = op; v.alu = a; v.rs2 = d; v.rs2a = 4; v.ack = 1;
      v.e_req = 1; v.e_be = be; v.e_addr = {a[31:2], 2'b00}; v.e_wdata = wd;
      return v;
   endfunction
   function automatic vec_t errv(logic rd, logic wr, logic [3:0] op, logic [31:0] a);
      vec_t v = blank();
      v.rd = rd; v.wr = wr; v.op = op; v.alu = a; v.rwe = rd; v.m2r = rd; v.rda = 5; v.ack = 1;
      v.e_exc = 1;
      return v;
   endfunction
   task automatic apply(input vec_t v);
      EX_mem_wr_en_i = v.wr; EX_mem_rd_en_i = v.rd; EX_mem_op_i = v.op;
      EX_rs2_data_i = v.rs2; EX_rs2_addr_i = v.rs2a; EX_alu_result_i = v.alu;
      EX_memtoreg_i = v.m2r; EX_rd_wr_en_i = v.rwe; EX_rd_addr_i = v.rda; EX_exception_i = v.exc;
      WB_rd_wr_en_i = v.wbe; WB_rd_addr_i = v.wba; WB_rd_wr_data_i = v.wbd;
      dmem_ack_i = v.ack; dmem_rdata_i = v.rdata;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic ld_wait(input logic [3:0] op, input logic [31:0] exp);
      vec_t v = ldv(op, 32'h103, 32'h80112233, 4'b1000, exp);
      v.ack = 0;
      @(negedge clk_i);
      apply(v);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk_i);
         dmem_ack_i = (c == 3);
         #1;
         chk($sformatf("wait_stall c%0d", c), 32'(MEM_stall_o), 32'(c < 3));
         chk($sformatf("wait_req c%0d", c), 32'(dmem_req_o), 32'd1);
         chk($sformatf("wait_addr c%0d", c), dmem_addr_o, 32'h100);
         @(posedge clk_i);
         #1;
         if (c < 3) chk($sformatf("wait_bubble c%0d", c), 32'(MEM_rd_wr_en_o), 32'd0);
      end
      chk("wait_load", MEM_load_data_o, exp);
      chk("wait_rwe", 32'(MEM_rd_wr_en_o), 32'd1);
   endtask
   initial begin
      vec_t v;
      int n;
      apply(stv(OP_SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF));
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_stall", 32'(MEM_stall_o), 32'd0);
      chk("rst_mem", {MEM_rd_wr_en_o, MEM_memtoreg_o, MEM_exception_o, MEM_rd_addr_o}, 32'd0);
      chk("rst_alu", MEM_alu_result_o | MEM_load_data_o, 32'd0);
      @(negedge clk_i);
      apply(blank());
      resetn_i = 1'b1;
      vecs.push_back(stv(OP_SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF));
      vecs.push_back(stv(OP_SH, 32'h102, 32'h00001234, 4'b1100, 32'h12341234));
      vecs.push_back(stv(OP_SB, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB));
      vecs.push_back(errv(1, 0, OP_LW, 32'h102));
      vecs.push_back(errv(1, 0, OP_LH, 32'h101));
      vecs.push_back(errv(1, 0, 4'b0011, 32'h100));
      vecs.push_back(errv(0, 1, OP_SW, 32'h101));
      vecs.push_back(ldv(OP_LB, 32'h103, 32'h80112233, 4'b1000, 32'hFFFFFF80));
      vecs.push_back(ldv(OP_LBU, 32'h103, 32'h80112233, 4'b1000, 32'h00000080));
      vecs.push_back(ldv(OP_LH, 32'h102, 32'h80015555, 4'b1100, 32'hFFFF8001));
      vecs.push_back(ldv(OP_LHU, 32'h000, 32'h1234F00D, 4'b0011, 32'h0000F00D));
      vecs.push_back(ldv(OP_LW, 32'h004, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D));
      vecs.push_back(ldv(OP_LB, 32'h101, 32'h00007F00, 4'b0010, 32'h0000007F));
      v = blank(); v.alu = 32'h12345678; v.rwe = 1; v.rda = 3; v.ack = 1; v.rdata = 32'hFFFFFFFF; v.e_rwe = 1;
      vecs.push_back(v);
      v = ldv(OP_LW, 32'h200, 32'h11223344, 4'b1111, 32'h0); v.exc = 1; v.rwe = 0; v.m2r = 0;
      v.e_req = 0; v.e_exc = 1; v.e_rwe = 0; v.e_m2r = 0;
      vecs.push_back(v);
      v = stv(OP_SW, 32'h300, 32'h11111111, 4'b1111, 32'h5A5A5A5A); v.rs2a = 9; v.wbe = 1; v.wba = 9; v.wbd = 32'h5A5A5A5A;
      vecs.push_back(v);
      v = stv(OP_SW, 32'h300, 32'h22222222, 4'b1111, 32'h22222222); v.rs2a = 0; v.wbe = 1; v.wba = 0; v.wbd = 32'h5A5A5A5A;
      vecs.push_back(v);
      foreach (vecs[i]) begin
         @(negedge clk_i);
         apply(vecs[i]);
         #1;
         chk($sformatf("v%0d req", i), 32'(dmem_req_o), 32'(vecs[i].e_req));
         chk($sformatf("v%0d stall", i), 32'(MEM_stall_o), 32'd0);
         if (vecs[i].e_req) begin
            chk($sformatf("v%0d addr", i), dmem_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d be", i), 32'(dmem_be_o), 32'(vecs[i].e_be));
            chk($sformatf("v%0d we", i), 32'(dmem_we_o), 32'(vecs[i].wr));
            if (vecs[i].wr) chk($sformatf("v%0d wdata", i), dmem_wdata_o, vecs[i].e_wdata);
         end
         @(posedge clk_i);
         #1;
         chk($sformatf("v%0d rwe", i), 32'(MEM_rd_wr_en_o), 32'(vecs[i].e_rwe));
         chk($sformatf("v%0d m2r", i), 32'(MEM_memtoreg_o), 32'(vecs[i].e_m2r));
         chk($sformatf("v%0d exc", i), 32'(MEM_exception_o), 32'(vecs[i].e_exc));
         chk($sformatf("v%0d rd", i), 32'(MEM_rd_addr_o), 32'(vecs[i].rda));
         chk($sformatf("v%0d alu", i), MEM_alu_result_o, vecs[i].alu);
         chk($sformatf("v%0d load", i), MEM_load_data_o, vecs[i].e_load);
      end
      ld_wait(OP_LB, 32'hFFFFFF80);
      ld_wait(OP_LBU, 32'h00000080);
      v = stv(OP_SW, 32'h200, 32'h0BADF00D, 4'b1111, 32'h0BADF00D); v.ack = 0;
      @(negedge clk_i);
      apply(v);
      n = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (!dmem_req_o) break;
         n += int'(MEM_stall_o);
         @(posedge clk_i);
         #1;
         chk($sformatf("to_exc c%0d", c), 32'(MEM_exception_o), 32'd0);
         @(negedge clk_i);
      end
      chk("to_stall_cycles", 32'(n), 32'd4);
      chk("to_stall_drop", 32'(MEM_stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      chk("to_exc", 32'(MEM_exception_o), 32'd1);
      chk("to_rwe", 32'(MEM_rd_wr_en_o), 32'd0);
      v = ldv(OP_LW, 32'h300, 32'h0, 4'b1111, 32'h0); v.ack = 0;
      @(negedge clk_i);
      apply(v);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("rw_req_before", 32'(dmem_req_o), 32'd1);
      resetn_i = 1'b0;
      #1;
      chk("rw_req", 32'(dmem_req_o), 32'd0);
      chk("rw_mem", {MEM_rd_wr_en_o, MEM_memtoreg_o, MEM_exception_o, MEM_rd_addr_o}, 32'd0);
      @(negedge clk_i);
      apply(blank());
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'hFFFFFFFF;
      resetn_i = 1'b1;
      #1;
      chk("rw_late_req", 32'(dmem_req_o), 32'd0);
      @(posedge clk_i);
      #1;
      chk("rw_late_rwe", 32'(MEM_rd_wr_en_o), 32'd0);
      chk("rw_late_load", MEM_load_data_o, 32'd0);
      chk("rw_late_exc", 32'(MEM_exception_o), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
